// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encodings and datapath width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_unit_div_step.sv
// One radix-2 restoring division iteration: shift {rem,dvd}, trial-subtract divisor, restore on borrow.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out
);

  logic [WIDTH:0] part;
  logic [WIDTH:0] trial;
  logic           q_bit;

  // Partial remainder always stays below the divisor, so WIDTH+1 bits cannot overflow.
  assign part    = {rem_in, dvd_in[WIDTH-1]};
  assign trial   = part - {1'b0, dsr};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : part[WIDTH-1:0];
  assign dvd_out = {dvd_in[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider (quotient to LO, remainder to HI) with pipeline stall.
// Optional early-out for divide-by-zero and |a|<|b| when DIV_FAST_EN is defined.
//
// state    | meaning
// DIV_IDLE | waiting for start; latches operand magnitudes and signs
// DIV_BUSY | one restoring step per cycle, WIDTH cycles
// DIV_DONE | result registered, valid pulses, pipeline released
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] part;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             fast_hit;
  logic             last_step;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;

  assign a_mag     = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_div && b[WIDTH-1]) ? -b : b;
  assign b_zero    = (b == '0);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_FAST_EN
  assign fast_hit = b_zero || (a_mag < b_mag);
`else
  assign fast_hit = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (part),
    .dvd_in  (dvd),
    .dsr     (dsr),
    .rem_out (step_rem),
    .dvd_out (step_dvd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (annul) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start) state_nxt = fast_hit ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (last_step) state_nxt = DIV_DONE;
        DIV_DONE: state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  // stall is forced low during reset even if the decoder still presents start.
  always_comb begin
    stall = 1'b0;
    valid = 1'b0;
    case (state)
      DIV_IDLE: stall = resetn & start & ~annul;
      DIV_BUSY: stall = resetn;
      DIV_DONE: valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      part  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else if (!annul) begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            dvd   <= a_mag;
            dsr   <= b_mag;
            part  <= '0;
            cnt   <= '0;
            // Divide-by-zero keeps the raw all-ones quotient in signed mode too.
            neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]) & ~b_zero;
            neg_r <= signed_div & a[WIDTH-1];
            if (fast_hit) begin
              quot <= b_zero ? '1 : '0;
              rem  <= a;
            end
          end
        end
        DIV_BUSY: begin
          dvd  <= step_dvd;
          part <= step_rem;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            quot <= neg_q ? -step_dvd : step_dvd;
            rem  <= neg_r ? -step_rem : step_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected quot/rem, latency and stall-length checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        valid;
  logic [31:0] quot;
  logic [31:0] rem;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q_exp[$];
  logic [31:0] r_exp[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .stall      (stall),
    .valid      (valid),
    .quot       (quot),
    .rem        (rem)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] xm;
    logic [31:0] ym;
    xm = (s && x[31]) ? -x : x;
    ym = (s && y[31]) ? -y : y;
`ifdef DIV_FAST_EN
    if (y == 32'd0 || xm < ym) return 1;
`endif
    if (xm == ym) return 33;
    return 33;
  endfunction

  // Issues one divide, holding start until valid, then checks latency, stall length and result.
  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [31:0] eq, input logic [31:0] er, input string name);
    int          lat;
    int          stall_cnt;
    int          want_lat;
    bit          got;
    logic [31:0] pq;
    logic [31:0] pr;
    want_lat = exp_latency(ta, tb, ts);
    q_exp.push_back(eq);
    r_exp.push_back(er);
    @(negedge clk);
    a = ta; b = tb; signed_div = ts; start = 1'b1;
    lat = 0; stall_cnt = 0; got = 0;
    while (!got && lat < 100) begin
      #1;
      if (stall) stall_cnt++;
      if (valid) got = 1;
      if (!got) begin
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    pq = q_exp.pop_front();
    pr = r_exp.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s valid timeout: no valid within %0d cycles", name, lat);
    end else begin
      n_checks++;
      if (lat !== want_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, want_lat);
      end
      n_checks++;
      if (stall_cnt !== want_lat) begin
        n_fail++;
        $display("FAIL %s stall cycles: got %0d expected %0d", name, stall_cnt, want_lat);
      end
      n_checks++;
      if (quot !== pq) begin
        n_fail++;
        $display("FAIL %s quot: got %h expected %h", name, quot, pq);
      end
      n_checks++;
      if (rem !== pr) begin
        n_fail++;
        $display("FAIL %s rem: got %h expected %h", name, rem, pr);
      end
    end
    last_q = pq;
    last_r = pr;
    @(negedge clk);
    #1;
    n_checks++;
    if (valid !== 1'b0 || quot !== pq || rem !== pr) begin
      n_fail++;
      $display("FAIL %s after done: valid=%b quot=%h rem=%h expected valid=0 quot=%h rem=%h",
               name, valid, quot, rem, pq, pr);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; signed_div = 1'b0; annul = 1'b0; a = 32'd5; b = 32'd1;
    #12;
    n_checks++;
    if (stall !== 1'b0 || valid !== 1'b0 || quot !== 32'd0 || rem !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: stall=%b valid=%b quot=%h rem=%h expected all zero",
               stall, valid, quot, rem);
    end
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "udiv_100_7");
    do_div(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, "udiv_small");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, "udiv_big");
  endtask

  task automatic test_signed();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "sdiv_m7_2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "sdiv_7_m2");
    do_div(32'hFFFF_FFFE, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'hFFFF_FFFE, "sdiv_small_neg");
  endtask

  task automatic test_overflow();
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "sdiv_overflow");
  endtask

  task automatic test_div_zero();
    do_div(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, "udiv_zero");
    do_div(32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, "sdiv_zero");
    do_div(32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, "sdiv_zero_neg");
  endtask

  task automatic test_annul();
    @(negedge clk);
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL annul busy stall: got %b expected 1", stall);
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || valid !== 1'b0 || quot !== last_q || rem !== last_r) begin
      n_fail++;
      $display("FAIL annul: stall=%b valid=%b quot=%h rem=%h expected stall=0 valid=0 quot=%h rem=%h",
               stall, valid, quot, rem, last_q, last_r);
    end
    do_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "after_annul");
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 4) y = {16'hFFFF, y[15:0]};
      s = i[0];
      model(x, y, s, q, r);
      do_div(x, y, s, q, r, $sformatf("rand_%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'd50; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || valid !== 1'b0 || quot !== 32'd0 || rem !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: stall=%b valid=%b quot=%h rem=%h expected all zero",
               stall, valid, quot, rem);
    end
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    do_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
